// File: rtl/rf_pkg.sv
// Shared regfile writeback constants: widths, requester indices, starvation default.
package rf_pkg;
    localparam int RF_AW         = 5;
    localparam int RF_DW         = 32;
    localparam int REQ_WB        = 0;
    localparam int REQ_MDU       = 1;
    localparam int REQ_LSU       = 2;
    localparam int RF_STARVE_MAX = 4;
endpackage

// File: rtl/rr_pick.sv
// N-way picker: first request at or after ptr, wrapping; ptr tied to 0 gives fixed lowest-index priority.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic found;

    // Two passes: indices >= ptr first, then the wrapped-around remainder.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: requester 0 has priority, secondaries protected by a starvation guard.
// Define RF_WB_ARB_RR_EN for round-robin among secondaries; otherwise lowest index wins.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic [2**AW-1:0]   pend_mask,
    output logic               starve_force
);
    localparam int NS = NREQ - 1;
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic [NS-1:0]   sec_valid;
    logic [NS-1:0]   sec_gnt;
    logic [PW-1:0]   ptr;
    logic            any_sec;
    logic            force_sel;
    logic            xfer;
    logic [NREQ-1:0] gnt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;
    logic [2**AW-1:0] pend;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*AW +: AW];
        assign data_arr[gi] = req_data[gi*DW +: DW];
    end

    assign sec_valid = req_valid[NREQ-1:REQ_MDU];
    assign any_sec   = |sec_valid;
    assign force_sel = any_sec && (starve_cnt_q == 4'(STARVE_MAX));

    rr_pick #(.N(NS), .PW(PW)) u_pick (
        .req (sec_valid),
        .ptr (ptr),
        .gnt (sec_gnt)
    );

    always_comb begin
        gnt = '0;
        if (req_valid[REQ_WB] && !force_sel) begin
            gnt[REQ_WB] = 1'b1;
        end else begin
            gnt[NREQ-1:REQ_MDU] = sec_gnt;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = addr_arr[i];
                sel_data = data_arr[i];
            end
        end
    end

    assign xfer = |gnt;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!any_sec || (|gnt[NREQ-1:REQ_MDU])) begin
            starve_cnt_d = '0;
        end else if (gnt[REQ_WB]) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        rf_we_d = xfer && (sel_addr != '0);
        rf_wa_d = xfer ? sel_addr : rf_wa_q;
        rf_wd_d = xfer ? sel_data : rf_wd_q;
    end

`ifdef RF_WB_ARB_RR_EN
    // Pointer is held in secondary-relative form: 0 means requester 1.
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        for (int j = 0; j < NS; j++) begin
            if (gnt[j+1]) begin
                ptr_d = (j == NS - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
        end
    end

    // Register 0 is never a real hazard, so its bit is forced clear.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                pend[addr_arr[i]] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pend[rf_wa_q] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign req_ready    = gnt;
    assign starve_force = force_sel;
    assign pend_mask    = pend;
    assign rf_we        = rf_we_q;
    assign rf_wa        = rf_wa_q;
    assign rf_wd        = rf_wd_q;
endmodule
